// File: rtl/fft_post_ac_dc.sv
// Post-FFT AC/DC extraction: alpha-max-beta-min magnitude per bin, DC from bin 0,
// AC as the peak magnitude over a configurable bin band, committed once per frame.
module fft_post_ac_dc #(
    parameter int N_BINS = 1024,
    parameter int DW     = 22,
    parameter int BIN_LO = 2,
    parameter int BIN_HI = 40
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      fft_sync,
    input  logic [2*DW-1:0]           fft_data,
    output logic [DW-1:0]             AC_comp,
    output logic [DW-1:0]             DC_comp,
    output logic [$clog2(N_BINS)-1:0] peak_bin,
    output logic                      new_comp_DV,
    output logic                      frame_err
);

    localparam int TAG_W = $clog2(N_BINS);
    localparam int CNT_W = TAG_W + 1;

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_COLLECT = 1'b1;

    localparam logic [CNT_W-1:0] CNT_IDLE = CNT_W'(N_BINS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BINS - 1);
    localparam logic [TAG_W-1:0] TAG_LAST = TAG_W'(N_BINS - 1);
    localparam logic [TAG_W-1:0] TAG_LO   = TAG_W'(BIN_LO);
    localparam logic [TAG_W-1:0] TAG_HI   = TAG_W'(BIN_HI);

    // |x| with the most-negative code clamped to the largest positive value
    function automatic logic [DW-1:0] abs_sat(input logic signed [DW-1:0] x);
        logic signed [DW-1:0] neg;
        neg = -x;
        if (x == {1'b1, {(DW-1){1'b0}}})
            return {1'b0, {(DW-1){1'b1}}};
        else if (x[DW-1])
            return $unsigned(neg);
        else
            return $unsigned(x);
    endfunction

    // mx + 0.375*mn; bounded by 1.375 * 2^(DW-1) so it never overflows DW bits
    function automatic logic [DW-1:0] mag_approx(input logic [DW-1:0] mx, input logic [DW-1:0] mn);
        return mx + (mn >> 2) + (mn >> 3);
    endfunction

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vld_p1_q, vld_p1_d;
    logic             vld_p2_q, vld_p2_d;
    logic             vld_p3_q, vld_p3_d;

    logic signed [DW-1:0] re_in, im_in;
    logic [TAG_W-1:0]     in_tag;
    logic                 abort;

    logic [DW-1:0]    abs_re_p1_q, abs_re_p1_d, abs_im_p1_q, abs_im_p1_d;
    logic [TAG_W-1:0] tag_p1_q, tag_p1_d;
    logic [DW-1:0]    mx_p2_q, mx_p2_d, mn_p2_q, mn_p2_d;
    logic [TAG_W-1:0] tag_p2_q, tag_p2_d;
    logic [DW-1:0]    mag_p3_q, mag_p3_d;
    logic [TAG_W-1:0] tag_p3_q, tag_p3_d;

    logic [DW-1:0]    dc_acc_q, dc_acc_d, pk_acc_q, pk_acc_d;
    logic [TAG_W-1:0] idx_acc_q, idx_acc_d;
    logic [DW-1:0]    base_pk;
    logic [TAG_W-1:0] base_idx;
    logic             acc_en, in_band, commit;

    logic [DW-1:0]    ac_q, ac_d, dc_q, dc_d;
    logic [TAG_W-1:0] peak_q, peak_d;
    logic             dv_q, dv_d, err_q, err_d;

    // Framing: cnt_q holds the index of the next expected bin, CNT_IDLE when no frame is open
    always_comb begin
        re_in   = $signed(fft_data[2*DW-1:DW]);
        im_in   = $signed(fft_data[DW-1:0]);
        abort   = fft_sync && (state_q == S_COLLECT);
        in_tag  = fft_sync ? '0 : cnt_q[TAG_W-1:0];
        state_d = state_q;
        cnt_d   = cnt_q;
        if (fft_sync) begin
            state_d = S_COLLECT;
            cnt_d   = CNT_W'(1);
        end else if (state_q == S_COLLECT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                state_d = S_IDLE;
                cnt_d   = CNT_IDLE;
            end
        end
        vld_p1_d = fft_sync || (state_q == S_COLLECT);
        vld_p2_d = vld_p1_q && !abort;
        vld_p3_d = vld_p2_q && !abort;
    end

    // Stage p1: component magnitudes
    always_comb begin
        abs_re_p1_d = abs_sat(re_in);
        abs_im_p1_d = abs_sat(im_in);
        tag_p1_d    = in_tag;
    end

    // Stage p2: order the components
    always_comb begin
        mx_p2_d  = (abs_re_p1_q >= abs_im_p1_q) ? abs_re_p1_q : abs_im_p1_q;
        mn_p2_d  = (abs_re_p1_q >= abs_im_p1_q) ? abs_im_p1_q : abs_re_p1_q;
        tag_p2_d = tag_p1_q;
    end

    // Stage p3: approximate magnitude
    always_comb begin
        mag_p3_d = mag_approx(mx_p2_q, mn_p2_q);
        tag_p3_d = tag_p2_q;
    end

    // Accumulate on the p3 output; a tag-0 bin restarts the peak search
    always_comb begin
        acc_en    = vld_p3_q && !abort;
        in_band   = (tag_p3_q >= TAG_LO) && (tag_p3_q <= TAG_HI);
        base_pk   = (tag_p3_q == '0) ? '0 : pk_acc_q;
        base_idx  = (tag_p3_q == '0) ? TAG_LO : idx_acc_q;
        dc_acc_d  = dc_acc_q;
        pk_acc_d  = pk_acc_q;
        idx_acc_d = idx_acc_q;
        if (acc_en) begin
            if (tag_p3_q == '0)
                dc_acc_d = mag_p3_q;
            pk_acc_d  = base_pk;
            idx_acc_d = base_idx;
            if (in_band && (mag_p3_q > base_pk)) begin
                pk_acc_d  = mag_p3_q;
                idx_acc_d = tag_p3_q;
            end
        end
        commit = acc_en && (tag_p3_q == TAG_LAST);
        ac_d   = commit ? pk_acc_d  : ac_q;
        dc_d   = commit ? dc_acc_d  : dc_q;
        peak_d = commit ? idx_acc_d : peak_q;
        dv_d   = commit;
        err_d  = abort;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= CNT_IDLE;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            ac_q     <= '0;
            dc_q     <= '0;
            peak_q   <= '0;
            dv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            vld_p3_q <= vld_p3_d;
            ac_q     <= ac_d;
            dc_q     <= dc_d;
            peak_q   <= peak_d;
            dv_q     <= dv_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        abs_re_p1_q <= abs_re_p1_d;
        abs_im_p1_q <= abs_im_p1_d;
        tag_p1_q    <= tag_p1_d;
        mx_p2_q     <= mx_p2_d;
        mn_p2_q     <= mn_p2_d;
        tag_p2_q    <= tag_p2_d;
        mag_p3_q    <= mag_p3_d;
        tag_p3_q    <= tag_p3_d;
        dc_acc_q    <= dc_acc_d;
        pk_acc_q    <= pk_acc_d;
        idx_acc_q   <= idx_acc_d;
    end

    assign AC_comp     = ac_q;
    assign DC_comp     = dc_q;
    assign peak_bin    = peak_q;
    assign new_comp_DV = dv_q;
    assign frame_err   = err_q;

endmodule

// File: doc/fft_post_ac_dc.md
# fft_post_ac_dc

Post-FFT stage for the LED1 pulse-ox path. Consumes the streaming complex FFT output (one bin per clock, frame start marked by a sync pulse), computes an approximate magnitude per bin, and extracts DC (magnitude of bin 0) and AC (peak magnitude within the heart-rate bin band). Once per frame it produces the AC/DC pair plus the peak bin index with a one-cycle valid strobe, for the SpO2 ratio logic downstream.

## Interface
- N_BINS, 1024, bins per FFT frame (power of 2)
- DW, 22, width of each real/imag component and of the AC/DC outputs
- BIN_LO, 2, first bin included in the AC peak search
- BIN_HI, 40, last bin included in the AC peak search (BIN_LO ≤ BIN_HI < N_BINS)
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- fft_sync  in  1  high for exactly the cycle carrying bin 0
- fft_data  in  2*DW  signed complex bin: real [2*DW-1:DW], imag [DW-1:0]
- AC_comp  out  DW  unsigned peak magnitude in [BIN_LO, BIN_HI]
- DC_comp  out  DW  unsigned magnitude of bin 0
- peak_bin  out  log2(N_BINS)  index of the AC peak
- new_comp_DV  out  1  one-cycle strobe: AC_comp/DC_comp/peak_bin updated
- frame_err  out  1  one-cycle strobe: frame aborted by early fft_sync

## Operation
- Input framing: bin k of a frame arrives k cycles after the fft_sync cycle; one bin every cycle, no gaps. Data arriving with no frame open is ignored.
- Bin counter: loaded to 0 on fft_sync, increments each cycle; frame open while counter < N_BINS. Bin index travels as a tag alongside data through the pipeline.
- Magnitude (3-stage pipeline):
  - S1: |re|, |im|; most-negative input (-2^(DW-1)) saturates to 2^(DW-1)-1.
  - S2: mx = max(|re|,|im|), mn = min(|re|,|im|).
  - S3: mag = mx + (mn>>2) + (mn>>3) (alpha-max-beta-min, 1 and 3/8). Upper bound ≈1.375·2^(DW-1) < 2^DW, so mag fits DW bits unsigned; no saturation required.
- Accumulation (on S3 output, by tag):
  - tag 0: latch DC candidate; reset peak candidate to 0, peak index to BIN_LO.
  - BIN_LO ≤ tag ≤ BIN_HI: replace peak if mag > current peak (strict; ties keep lower bin).
  - tag N_BINS-1: commit DC/peak/index to outputs, pulse new_comp_DV.
- State machine: IDLE (no frame open) → COLLECT on fft_sync → IDLE after bin N_BINS-1 enters S1. fft_sync while in COLLECT with counter ≠ N_BINS restarts the frame: pulse frame_err, discard in-flight bins of old frame (pipeline valid bits cleared for old tags), new frame starts at bin 0 this cycle.
- Back-to-back frames (fft_sync on the cycle right after bin N_BINS-1) are legal, produce no frame_err, and lose no bins.
- Outputs hold last committed values until the next commit.

## Timing
- Reset: AC_comp, DC_comp, peak_bin, new_comp_DV, frame_err all 0; counter idle; pipeline valids cleared. Reset mid-frame discards the frame; no DV for it.
- Latency: fft_sync at cycle 0 → new_comp_DV high in cycle N_BINS+3 (outputs registered, valid same cycle as strobe).
- frame_err asserted the cycle after the offending fft_sync.
- Throughput: one frame per N_BINS cycles sustained.

## Test plan
- DC only: every bin re=1000, im=0 except bins 1..N-1 = 0 → DC_comp=1000, AC_comp=0, peak_bin=2, DV at cycle 1027.
- Tone: bin 0 (500,0); bin 10 (300,400); bin 20 (0,-200); others 0 → DC=500, AC=400+37+... = 400+75+37=512 (mx=400, mn=300), peak_bin=10.
- Saturation/out-of-band: bin 0 (-2^21,-2^21), bin 41 (1000000,0) → DC=2097151+524287+262143=2883581, bin 41 ignored, AC=0.
- Tie: bins 5 and 15 both (100,0) → AC=100, peak_bin=5.
- Two back-to-back frames, second with bin 30 (0,700) → two DVs 1024 cycles apart, second AC=700, peak_bin=30, frame_err never high.
- Early sync at bin 500 then full frame; separately reset_n low at bin 300 → one frame_err, only one DV (for complete frame); after reset all outputs 0, no DV.
